// File: rtl/trigger_sequencer_pkg.sv
// Shared types and default widths for the trigger sequencer.
// Holds the FSM state enum and the default counter/pulse-count widths.
package trigseq_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int NUM_W_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DELAY,
        S_HIGH,
        S_GAP
    } state_t;

endpackage

// File: rtl/trigger_sequencer_if.sv
// Handshake/config bundle between a controller and the trigger sequencer.
// master drives start/abort/cfg_*; slave drives trigger/busy/done/pulse_idx.
interface trigger_sequencer_if
    import trigseq_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int NUM_W = NUM_W_DEF
);

    logic             start;
    logic             abort;
    logic [CNT_W-1:0] cfg_delay;
    logic [CNT_W-1:0] cfg_width;
    logic [CNT_W-1:0] cfg_gap;
    logic [NUM_W-1:0] cfg_count;
    logic             trigger;
    logic             busy;
    logic             done;
    logic [NUM_W-1:0] pulse_idx;

    modport master (
        output start, abort,
        output cfg_delay, cfg_width,
        output cfg_gap, cfg_count,
        input  trigger, busy,
        input  done, pulse_idx
    );

    modport slave (
        input  start, abort,
        input  cfg_delay, cfg_width,
        input  cfg_gap, cfg_count,
        output trigger, busy,
        output done, pulse_idx
    );

endinterface

// File: rtl/trigger_sequencer_rise_detect.sv
// Rising-edge detector: pulse = in now high, low at the previous clock edge.
// Ports: clk, rst (sync, active-high), in, pulse (combinational, masked in reset).
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic pulse
);

    logic prev_q;

    // History tracks the input even during reset, so a level held high
    // across reset release is not seen as an edge.
    always_ff @(posedge clk) begin
        prev_q <= in;
    end

    assign pulse = in & ~prev_q & ~rst;

endmodule

// File: rtl/trigger_sequencer.sv
// Programmable pulse-train generator: delay, N pulses of width W, gap G.
// Ports: clk, rst (sync, active-high), bus (slave side of trigger_sequencer_if).
module trigger_sequencer
    import trigseq_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int NUM_W = NUM_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    trigger_sequencer_if.slave  bus
);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] delay_q;
    logic [CNT_W-1:0] wlast_q;
    logic [CNT_W-1:0] glast_q;
    logic [NUM_W-1:0] num_q;
    logic [NUM_W-1:0] idx_q;
    logic             trig_q;
    logic             busy_q;
    logic             done_q;

    logic             edge_w;
    logic [NUM_W:0]   idx_nx;
    logic             more_w;

    // Terminal count for a phase of length v; zero length acts as one.
    function automatic logic [CNT_W-1:0] last_of(
        input logic [CNT_W-1:0] v
    );
        return (v == '0) ? '0 : v - CNT_W'(1);
    endfunction

    rise_detect u_rise (
        .clk   (clk),
        .rst   (rst),
        .in    (bus.start),
        .pulse (edge_w)
    );

    // One extra bit so the compare stays correct at the top of the range.
    assign idx_nx = {1'b0, idx_q} + (NUM_W + 1)'(1);
    assign more_w = idx_nx < {1'b0, num_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            delay_q <= '0;
            wlast_q <= '0;
            glast_q <= '0;
            num_q   <= '0;
            idx_q   <= '0;
            trig_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (bus.abort) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            trig_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (edge_w) begin
                        delay_q <= bus.cfg_delay;
                        wlast_q <= last_of(bus.cfg_width);
                        glast_q <= last_of(bus.cfg_gap);
                        num_q   <= bus.cfg_count;
                        idx_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= S_DELAY;
                    end
                end
                S_DELAY: begin
                    busy_q <= 1'b1;
                    if (num_q == '0) begin
                        // Empty train: a silent HIGH phase that ends on
                        // the next edge, giving one busy cycle then done.
                        cnt_q   <= wlast_q;
                        state_q <= S_HIGH;
                    end else if (cnt_q == delay_q) begin
                        cnt_q   <= '0;
                        trig_q  <= 1'b1;
                        state_q <= S_HIGH;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_HIGH: begin
                    if (cnt_q == wlast_q) begin
                        cnt_q  <= '0;
                        trig_q <= 1'b0;
                        if (more_w) begin
                            state_q <= S_GAP;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (cnt_q == glast_q) begin
                        cnt_q   <= '0;
                        trig_q  <= 1'b1;
                        idx_q   <= idx_nx[NUM_W-1:0];
                        state_q <= S_HIGH;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.trigger   = trig_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pulse_idx = idx_q;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Scoreboard bench for trigger_sequencer: stimulus pushes expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_trigger_sequencer;
    import trigseq_pkg::*;

    localparam int CW = 8;
    localparam int NW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    trigger_sequencer_if #(.CNT_W(CW), .NUM_W(NW)) bus ();

    trigger_sequencer #(.CNT_W(CW), .NUM_W(NW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic          trig;
        logic          busy;
        logic          done;
        logic [NW-1:0] idx;
        int            tag;
        int            t;
    } exp_t;

    exp_t sb[$];
    int   n_vec    = 0;
    int   n_bad    = 0;
    int   last_idx = 0;

    // Expected outputs t cycles after the accepted edge E0.
    function automatic void model(
        input  int   t, d, w, g, n, ab_t,
        output logic tr, bu, dn,
        output int   ix
    );
        int we, ge, p, f, tt;
        we = (w == 0) ? 1 : w;
        ge = (g == 0) ? 1 : g;
        p  = we + ge;
        f  = (n == 0) ? 2 : 1 + d + (n - 1) * p + we;
        tt = (ab_t >= 0 && t >= ab_t) ? ab_t - 1 : t;
        tr = 1'b0;
        ix = 0;
        for (int k = 0; k < n; k++) begin
            if (t >= 1 + d + k * p && t <= d + we + k * p)
                tr = 1'b1;
            if (tt >= 1 + d + k * p)
                ix = k;
        end
        bu = (t >= 1 && t < f);
        dn = (t == f);
        if (ab_t >= 0 && t >= ab_t) begin
            tr = 1'b0;
            bu = 1'b0;
            dn = 1'b0;
        end
    endfunction

    task automatic step(
        input logic st, ab, rs,
        input int   d, w, g, n,
        input logic et, eb, ed,
        input int   ei, tag, t
    );
        exp_t e;
        @(negedge clk);
        bus.start     = st;
        bus.abort     = ab;
        rst           = rs;
        bus.cfg_delay = CW'(d);
        bus.cfg_width = CW'(w);
        bus.cfg_gap   = CW'(g);
        bus.cfg_count = NW'(n);
        @(posedge clk);
        e.trig = et;
        e.busy = eb;
        e.done = ed;
        e.idx  = NW'(ei);
        e.tag  = tag;
        e.t    = t;
        sb.push_back(e);
        last_idx = ei;
    endtask

    // One sequence: start low for one edge, then rising at E0 (t=0).
    // ab_t: abort edge; rs_t: reset edge; ds_t: re-edge + cfg change.
    task automatic scenario(
        input int tag, d, w, g, n,
        input int ab_t, rs_t, ds_t
    );
        int   we, ge, f, len, ei;
        int   cd, cw, cg, cn;
        logic st, et, eb, ed;
        we  = (w == 0) ? 1 : w;
        ge  = (g == 0) ? 1 : g;
        f   = (n == 0) ? 2 : 1 + d + (n - 1) * (we + ge) + we;
        len = f + 2;
        if (ab_t >= 0) len = ab_t + 1;
        if (rs_t >= 0) len = rs_t + 3;
        step(1'b0, 1'b0, 1'b0, d, w, g, n,
             1'b0, 1'b0, 1'b0, last_idx, tag, -1);
        for (int t = 0; t < len; t++) begin
            st = 1'b1;
            cd = d; cw = w; cg = g; cn = n;
            if (ds_t > 0 && t == ds_t - 1) st = 1'b0;
            if (ds_t > 0 && t >= ds_t) begin
                cd = 0; cw = 9; cg = 9; cn = 7;
            end
            model(t, d, w, g, n, ab_t, et, eb, ed, ei);
            if (rs_t >= 0 && t >= rs_t) begin
                et = 1'b0; eb = 1'b0; ed = 1'b0; ei = 0;
            end
            step(st, 1'(t == ab_t), 1'(t == rs_t),
                 cd, cw, cg, cn, et, eb, ed, ei, tag, t);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_vec++;
                if (bus.trigger !== e.trig || bus.busy !== e.busy ||
                    bus.done !== e.done || bus.pulse_idx !== e.idx) begin
                    n_bad++;
                    $display("FAIL vec s%0d t=%0d: got trig=%b busy=%b done=%b idx=%0d, want trig=%b busy=%b done=%b idx=%0d",
                             e.tag, e.t, bus.trigger, bus.busy,
                             bus.done, bus.pulse_idx, e.trig,
                             e.busy, e.done, e.idx);
                end
            end
        end
    end

    initial begin : stim
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.cfg_delay = '0;
        bus.cfg_width = '0;
        bus.cfg_gap   = '0;
        bus.cfg_count = '0;

        // start held high through reset and after release: nothing arms
        repeat (2)
            step(1'b1, 1'b0, 1'b1, 1, 1, 1, 1,
                 1'b0, 1'b0, 1'b0, 0, 1, 0);
        repeat (3)
            step(1'b1, 1'b0, 1'b0, 1, 1, 1, 1,
                 1'b0, 1'b0, 1'b0, 0, 1, 1);

        scenario(2, 2, 3, 1, 2, -1, -1, -1);
        scenario(3, 0, 0, 0, 3, -1, -1, -1);
        scenario(4, 5, 4, 4, 0, -1, -1, -1);
        scenario(5, 2, 3, 1, 2, -1, -1, 4);
        scenario(6, 2, 3, 1, 2, 4, -1, -1);
        scenario(7, 1, 1, 2, 2, -1, -1, -1);

        // abort coincident with a start edge: edge is dropped
        step(1'b0, 1'b0, 1'b0, 0, 1, 1, 1,
             1'b0, 1'b0, 1'b0, last_idx, 8, -1);
        step(1'b1, 1'b1, 1'b0, 0, 1, 1, 1,
             1'b0, 1'b0, 1'b0, last_idx, 8, 0);
        for (int i = 1; i < 4; i++)
            step(1'b1, 1'b0, 1'b0, 0, 1, 1, 1,
                 1'b0, 1'b0, 1'b0, last_idx, 8, i);

        scenario(9, 1, 2, 1, 3, -1, 3, -1);
        scenario(10, 255, 255, 255, 2, -1, -1, -1);
        scenario(11, 3, 1, 2, 4, -1, -1, -1);

        repeat (2) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d vectors left, want 0",
                     sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
